// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator control/status bundle: redirect requests in, fetch address and RAS status out.
interface fetch_pc_gen_if #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stall;
    logic              branch;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              call;
    logic              ret;
    logic              halt;
    logic [ADDR_W-1:0] pc_o;
    logic              pc_valid_o;
    logic              halted_o;
    logic [CNT_W-1:0]  ras_count_o;
    logic              ras_err_o;

    modport master (
        output start, start_addr, stall, branch, taken, target, call, ret, halt,
        input  pc_o, pc_valid_o, halted_o, ras_count_o, ras_err_o
    );

    modport slave (
        input  start, start_addr, stall, branch, taken, target, call, ret, halt,
        output pc_o, pc_valid_o, halted_o, ras_count_o, ras_err_o
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter: IDLE/RUN/HALTED FSM, stall, branch/call/ret redirects
// and a circular return-address stack that overwrites its oldest entry when full.
module fetch_pc_gen #(
    parameter int ADDR_W    = 8,
    parameter int STEP      = 1,
    parameter int RAS_DEPTH = 4
) (
    input logic           f_clk,
    input logic           rst,
    fetch_pc_gen_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            r_state, w_nxt_state;
    logic [ADDR_W-1:0] r_pc, w_nxt_pc, w_seq_pc;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp, w_wp_inc, w_wp_dec;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err, w_err, w_push, w_pop, w_clr;

    assign w_seq_pc = r_pc + ADDR_W'(STEP);
    // r_wp is the next push slot; top of stack sits one below it (modulo depth)
    assign w_wp_inc = (r_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wp + PTR_W'(1);
    assign w_wp_dec = (r_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wp - PTR_W'(1);

    always_ff @(posedge f_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_clr       = 1'b0;
        if (bus.start) begin
            w_nxt_state = S_RUN;
            w_nxt_pc    = bus.start_addr;
            w_clr       = 1'b1;
        end else if (r_state == S_RUN) begin
            if (bus.halt) begin
                w_nxt_state = S_HALTED;
            end else if (bus.stall) begin
                w_nxt_pc = r_pc;
            end else if (bus.call) begin
                w_push   = 1'b1;
                w_nxt_pc = bus.target;
            end else if (bus.ret) begin
                if (r_cnt != '0) begin
                    w_pop    = 1'b1;
                    w_nxt_pc = r_ras[w_wp_dec];
                end else begin
                    w_err    = 1'b1;
                    w_nxt_pc = w_seq_pc;
                end
            end else if (bus.branch && bus.taken) begin
                w_nxt_pc = bus.target;
            end else begin
                w_nxt_pc = w_seq_pc;
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_wp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_nxt_pc;
            r_err <= w_err;
            if (w_clr) begin
                r_wp  <= '0;
                r_cnt <= '0;
            end else if (w_push) begin
                r_wp  <= w_wp_inc;
                r_cnt <= (r_cnt == CNT_W'(RAS_DEPTH)) ? r_cnt : r_cnt + CNT_W'(1);
            end else if (w_pop) begin
                r_wp  <= w_wp_dec;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; contents are meaningless until pushed
    always_ff @(posedge f_clk) begin
        if (!rst && w_push) r_ras[r_wp] <= w_seq_pc;
    end

    assign bus.pc_o        = r_pc;
    assign bus.pc_valid_o  = (r_state == S_RUN);
    assign bus.halted_o    = (r_state == S_HALTED);
    assign bus.ras_count_o = r_cnt;
    assign bus.ras_err_o   = r_err;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: stimulus pushes hand-computed expectations, a monitor pops and checks.
module tb_fetch_pc_gen;
    logic f_clk = 1'b0;
    logic rst   = 1'b1;

    fetch_pc_gen_if #(.ADDR_W(8), .RAS_DEPTH(4)) bus ();

    fetch_pc_gen #(.ADDR_W(8), .STEP(1), .RAS_DEPTH(4)) dut (
        .f_clk (f_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 f_clk = ~f_clk;

    typedef struct {
        logic [7:0] pc;
        logic       v;
        logic       h;
        logic [2:0] c;
        logic       e;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic cyc(input string nm, input bit rs, st, ha, sl, ca, re, br, tk,
                       input logic [7:0] sa, tg,
                       input logic [7:0] epc, input bit ev, eh, input logic [2:0] ec, input bit ee);
        exp_t e;
        @(negedge f_clk);
        rst            = rs;
        bus.start      = st;
        bus.halt       = ha;
        bus.stall      = sl;
        bus.call       = ca;
        bus.ret        = re;
        bus.branch     = br;
        bus.taken      = tk;
        bus.start_addr = sa;
        bus.target     = tg;
        e.pc = epc; e.v = ev; e.h = eh; e.c = ec; e.e = ee; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [7:0] epc, input logic [2:0] ec);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, epc, 1, 0, ec, 0);
    endtask

    // Monitor: outputs settle after the edge; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge f_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.pc_o !== e.pc || bus.pc_valid_o !== e.v || bus.halted_o !== e.h ||
                    bus.ras_count_o !== e.c || bus.ras_err_o !== e.e)
                    $display("FAIL %s: got pc=%h v=%b h=%b cnt=%0d err=%b, want pc=%h v=%b h=%b cnt=%0d err=%b",
                             e.nm, bus.pc_o, bus.pc_valid_o, bus.halted_o, bus.ras_count_o, bus.ras_err_o,
                             e.pc, e.v, e.h, e.c, e.e);
                else
                    passed++;
            end
        end
    end

    initial begin
        bus.start = 0; bus.halt = 0; bus.stall = 0; bus.call = 0; bus.ret = 0;
        bus.branch = 0; bus.taken = 0; bus.start_addr = 0; bus.target = 0;

        // reset and first fetches
        cyc("reset0",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("reset1",   1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("idle",     0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("idle_ret", 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("start10",  0, 1, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0, 0, 0);
        idle("seq11", 8'h11, 0);
        idle("seq12", 8'h12, 0);
        idle("seq13", 8'h13, 0);

        // wrap and branches
        cyc("startFE",  0, 1, 0, 0, 0, 0, 0, 0, 8'hFE, 8'h00, 8'hFE, 1, 0, 0, 0);
        idle("seqFF", 8'hFF, 0);
        idle("wrap00", 8'h00, 0);
        cyc("br_taken", 0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h40, 8'h40, 1, 0, 0, 0);
        cyc("tk_nobr",  0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h90, 8'h41, 1, 0, 0, 0);

        // call / ret / empty ret
        cyc("start20",  0, 1, 0, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 1, 0, 0, 0);
        cyc("call80",   0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h80, 8'h80, 1, 0, 1, 0);
        idle("seq81", 8'h81, 1);
        idle("seq82", 8'h82, 1);
        cyc("ret21",    0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h21, 1, 0, 0, 0);
        cyc("ret_empty",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 0, 1);
        idle("err_clear", 8'h23, 0);

        // RAS overflow: pushes 02..06, oldest (02) overwritten
        cyc("start01",  0, 1, 0, 0, 0, 0, 0, 0, 8'h01, 8'h00, 8'h01, 1, 0, 0, 0);
        for (int i = 2; i <= 6; i++)
            cyc("ovf_call", 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'(i), 8'(i), 1, 0, 3'((i - 1 > 4) ? 4 : i - 1), 0);
        cyc("ovf_ret06",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h06, 1, 0, 3, 0);
        cyc("ovf_ret05",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h05, 1, 0, 2, 0);
        cyc("ovf_ret04",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h04, 1, 0, 1, 0);
        cyc("ovf_ret03",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h03, 1, 0, 0, 0);
        cyc("ovf_ret_e",0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h04, 1, 0, 0, 1);

        // stall / halt
        cyc("start30",  0, 1, 0, 0, 0, 0, 0, 0, 8'h30, 8'h00, 8'h30, 1, 0, 0, 0);
        cyc("stall1",   0, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h30, 1, 0, 0, 0);
        cyc("stall_tk", 0, 0, 0, 1, 0, 0, 1, 1, 8'h00, 8'h70, 8'h30, 1, 0, 0, 0);
        cyc("stall_ret",0, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h30, 1, 0, 0, 0);
        idle("resume31", 8'h31, 0);
        cyc("halt",     0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h31, 0, 1, 0, 0);
        cyc("halt_call",0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h99, 8'h31, 0, 1, 0, 0);
        cyc("halt_ret", 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h31, 0, 1, 0, 0);
        cyc("start50",  0, 1, 0, 0, 0, 0, 0, 0, 8'h50, 8'h00, 8'h50, 1, 0, 0, 0);

        // priority and reset override
        cyc("call90",   0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h90, 8'h90, 1, 0, 1, 0);
        cyc("start_hlt",0, 1, 1, 0, 0, 0, 0, 0, 8'h60, 8'h00, 8'h60, 1, 0, 0, 0);
        cyc("call_ret", 0, 0, 0, 0, 1, 1, 1, 1, 8'h00, 8'hA0, 8'hA0, 1, 0, 1, 0);
        cyc("rst_start",1, 1, 0, 0, 0, 0, 0, 0, 8'h77, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge f_clk);
        #3;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised program-counter generator for the fetch stage. Successor to the original 8-bit fetch unit: configurable address width and increment, registered PC with valid flag, stall support, a real halt state, and a circular return-address stack (RAS) for call/return. It sits between the control/branch-resolution logic and the instruction memory address port.

## Interface
- ADDR_W, 8: PC and target width in bits.
- STEP, 1: PC increment per sequential fetch, in address units.
- RAS_DEPTH, 4: return-address stack entries, ≥ 2.
- f_clk  in  1  fetch clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load start_addr and begin fetching.
- start_addr  in  ADDR_W  start address.
- stall  in  1  freeze PC and RAS this cycle.
- branch  in  1  current instruction is a conditional branch.
- taken  in  1  branch resolved taken; used only when branch=1.
- target  in  ADDR_W  branch/call destination.
- call  in  1  call: push return address, jump to target.
- ret  in  1  return: pop RAS, jump to popped address.
- halt  in  1  stop fetching.
- pc_o  out  ADDR_W  registered fetch address.
- pc_valid_o  out  1  pc_o is a live fetch address.
- halted_o  out  1  block is in HALTED.
- ras_count_o  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_err_o  out  1  one-cycle pulse: ret on empty RAS.

## Operation
- States: IDLE (after reset, no fetch), RUN, HALTED.
- IDLE: pc_valid_o=0; waits for start. HALTED: pc_valid_o=0, halted_o=1, pc_o held; only start or rst leaves.
- start (any state): pc <= start_addr, RAS cleared, state RUN.
- In RUN, per-cycle priority (highest first): start > halt > stall > call > ret > (branch && taken) > sequential.
- halt: state HALTED, pc held, RAS held; coincident redirects dropped.
- stall: pc, RAS, state held; redirects presented during stall are dropped (producer re-presents them).
- call: RAS push of pc_o+STEP; pc <= target. Push with RAS full overwrites oldest entry (circular); ras_count_o stays RAS_DEPTH.
- ret: RAS non-empty: pc <= top entry, pop. RAS empty: pc <= pc_o+STEP, ras_err_o=1 for one cycle, count stays 0.
- branch && taken: pc <= target. taken with branch=0 ignored.
- Sequential: pc <= pc_o+STEP, modulo 2^ADDR_W (wraps, no flag).
- Multiple of call/ret/taken in one cycle: only highest-priority acts.

## Timing
- All outputs registered; every action visible on outputs the cycle after the qualifying edge (1-cycle latency).
- Reset values: pc_o=0, pc_valid_o=0, halted_o=0, ras_count_o=0, ras_err_o=0, state IDLE, RAS contents don't-care.
- rst mid-operation overrides all inputs including start; RAS discarded.
- start and halt same cycle: start wins, state RUN.
- pc_valid_o=1 exactly while state is RUN (including stalled cycles).
- ras_err_o never asserted outside RUN or during stall/halt.
- Addresses are unsigned; no sign extension; STEP arithmetic truncated to ADDR_W.

## Test plan
- Reset then start, start_addr=0x10, 4 idle cycles -> pc_o 0x10,0x11,0x12,0x13, pc_valid_o=1; before start pc_o=0, pc_valid_o=0.
- Wrap: start_addr=0xFE, STEP=1 -> pc_o 0xFE,0xFF,0x00; branch=1,taken=1,target=0x40 -> next pc_o 0x40; taken with branch=0 -> ignored.
- Call/ret: at pc 0x20 call target 0x80 -> pc_o 0x80, ras_count_o=1; two sequential cycles then ret -> pc_o 0x21, count 0; second ret -> pc_o+1, ras_err_o pulses once.
- RAS overflow: five nested calls from pcs 0x01..0x05 (DEPTH 4) -> count 4; four rets return 0x06,0x05,0x04,0x03; fifth ret flags ras_err_o.
- Stall/halt: stall 3 cycles at 0x30 with taken asserted mid-stall -> pc_o stays 0x30, branch dropped, then resumes 0x31; halt -> halted_o=1, pc_valid_o=0, pc held; start 0x50 -> RUN at 0x50.
- Priority/reset: start+halt same cycle -> RUN; call+ret same cycle -> call only; rst asserted with start -> IDLE, all outputs at reset values.
